uart_rx: RTL and testbench

UART receiver for the FPGA serial link that carries plotter commands from the host. It recovers 8N1 frames (DATA_WIDTH data bits, LSB first, one stop bit) from the asynchronous `rx` line using the shared 16x oversampling tick `b_16tick`. It presents each received byte with a one-cycle `rx_done` strobe to the command parser. It runs from the same baud-tick generator and the same frame format as the UART transmitter.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// used by both the receiver and the transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int OVERSAMPLE = 16;
   localparam int START_MID  = 7;
   localparam int BIT_LAST   = 15;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. It resets to 1
// so the receiver sees an idle line straight out of reset.
module uart_rx_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on a 16x oversampling tick. Defining UART_RX_MAJORITY_EN
// makes every bit decision a 2-of-3 vote over the last three tick samples.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  rx,
   input  logic                  b_16tick,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_done,
   output logic                  rx_busy,
   output logic                  frame_err,
   output uart_state_e           rx_state
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic                  rx_s;
   uart_state_e           state_q, state_d;
   logic [3:0]            tick_cnt_q, tick_cnt_d;
   logic [CNT_W-1:0]      data_cnt_q, data_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_done_q, rx_done_d;
   logic                  frame_err_q, frame_err_d;
   logic                  bit_val;

   uart_rx_sync u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .d_i    (rx),
      .q_o    (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   logic [2:0] hist_q, hist_d;

   // The window ends with the current sample, so a vote is ready on the decision tick itself.
   assign hist_d  = b_16tick ? {hist_q[1:0], rx_s} : hist_q;
   assign bit_val = (hist_d[0] & hist_d[1]) | (hist_d[0] & hist_d[2]) | (hist_d[1] & hist_d[2]);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hist_q <= 3'b111;
      end else begin
         hist_q <= hist_d;
      end
   end
`else
   assign bit_val = rx_s;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         tick_cnt_q  <= '0;
         data_cnt_q  <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         data_cnt_q  <= data_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      data_cnt_d  = data_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            tick_cnt_d = '0;
            data_cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (b_16tick) begin
               if (tick_cnt_q == 4'(START_MID)) begin
                  tick_cnt_d = '0;
                  state_d    = bit_val ? IDLE : DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end
         DATA: begin
            if (b_16tick) begin
               if (tick_cnt_q == 4'(BIT_LAST)) begin
                  tick_cnt_d = '0;
                  shift_d    = {bit_val, shift_q[DATA_WIDTH-1:1]};
                  if (data_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                     data_cnt_d = '0;
                     state_d    = STOP;
                  end else begin
                     data_cnt_d = data_cnt_q + 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end
         STOP: begin
            if (b_16tick) begin
               if (tick_cnt_q == 4'(BIT_LAST)) begin
                  tick_cnt_d = '0;
                  state_d    = IDLE;
                  // A low stop bit discards the word but keeps the last good one visible.
                  if (bit_val) begin
                     rx_data_d = shift_q;
                     rx_done_d = 1'b1;
                  end else begin
                     frame_err_d = 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rx_busy   = (state_q != IDLE);
      rx_data   = rx_data_q;
      rx_done   = rx_done_q;
      frame_err = frame_err_q;
      rx_state  = state_q;
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand-written corner
// sequences and random frames checked against a line-level sampling model.
module tb_uart_rx;
   import uart_pkg::*;

   logic        clk      = 1'b0;
   logic        reset_n  = 1'b0;
   logic        rx       = 1'b1;
   logic        b_16tick = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic        rx_busy;
   logic        frame_err;
   uart_state_e rx_state;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   int err_seen = 0;
   int model_done = 0;
   int model_err = 0;
   logic [7:0] model_data = 8'h00;
   logic [7:0] exp_q[$];
   logic line_a[0:199];

   typedef struct {
      logic [7:0] data;
      logic       stop_ok;
      int         gap;
      logic       exp_done;
      logic       exp_err;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[4];

   always #5 clk = ~clk;

   uart_rx #(.DATA_WIDTH(8)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rx       (rx),
      .b_16tick (b_16tick),
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .rx_busy  (rx_busy),
      .frame_err(frame_err),
      .rx_state (rx_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every rx_done must deliver the next expected word.
   always @(negedge clk) begin
      if (reset_n) begin
         if (rx_done && frame_err) begin
            errors++;
            $display("FAIL strobe_overlap actual=both required=one");
         end
         if (rx_done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done actual=%0h required=none", rx_data);
            end else begin
               check("done_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
         end
         if (frame_err) err_seen++;
      end
   end

   // One oversampling slot: line value settles through the synchronizer, then one tick.
   task automatic send_slot(input logic v, output logic busy_pre, output logic done_post,
                            output logic err_post);
      @(negedge clk);
      rx = v;
      repeat (3) @(negedge clk);
      busy_pre = rx_busy;
      b_16tick = 1'b1;
      @(negedge clk);
      b_16tick  = 1'b0;
      done_post = rx_done;
      err_post  = frame_err;
   endtask

   function automatic logic sample_at(input int c);
`ifdef UART_RX_MAJORITY_EN
      int ones;
      ones = int'(line_a[c-2]) + int'(line_a[c-1]) + int'(line_a[c]);
      return (ones >= 2);
`else
      return line_a[c];
`endif
   endfunction

   task automatic run_frame(input logic [7:0] data, input logic stop_ok, input int gap,
                            input int glitch, output logic done_at, output logic err_at);
      int n;
      int busy_low;
      int busy_after;
      logic busy_pre, d_post, e_post;
      logic [7:0] word;
      logic stop_m;
      n = 160 + gap;
      busy_low = 0;
      busy_after = 0;
      done_at = 1'b0;
      err_at = 1'b0;
      for (int s = 0; s < n; s++) begin
         if (s < 16)       line_a[s] = 1'b0;
         else if (s < 144) line_a[s] = data[(s-16)/16];
         else if (s < 152) line_a[s] = stop_ok;
         else              line_a[s] = 1'b1;
         if (s == glitch) line_a[s] = 1'b1;
      end
      for (int k = 0; k < 8; k++) word[k] = sample_at(16*(k+1) + 7);
      stop_m = sample_at(151);
      if (stop_m) begin
         exp_q.push_back(word);
         model_data = word;
         model_done++;
      end else begin
         model_err++;
      end
      for (int s = 0; s < n; s++) begin
         send_slot(line_a[s], busy_pre, d_post, e_post);
         if (s <= 151 && !busy_pre) busy_low++;
         if (s > 151 && busy_pre) busy_after++;
         if (s == 151) begin
            done_at = d_post;
            err_at  = e_post;
         end
      end
      check("frame_done_strobe", 32'(done_at), 32'(stop_m));
      check("frame_err_strobe", 32'(err_at), 32'(!stop_m));
      check("frame_rx_data", 32'(rx_data), 32'(model_data));
      check("frame_busy_low", 32'(busy_low), 32'(0));
      if (stop_m) check("frame_busy_after", 32'(busy_after), 32'(0));
      check("frame_done_count", 32'(done_seen), 32'(model_done));
      check("frame_err_count", 32'(err_seen), 32'(model_err));
   endtask

   initial begin
      logic d_at, e_at, bp, dp, ep;
      logic busy7, busy8;
      int d0, e0;
      logic [7:0] g_exp;

      vecs[0] = '{data: 8'hA5, stop_ok: 1'b1, gap: 3, exp_done: 1'b1, exp_err: 1'b0, exp_data: 8'hA5};
      vecs[1] = '{data: 8'h3C, stop_ok: 1'b0, gap: 3, exp_done: 1'b0, exp_err: 1'b1, exp_data: 8'hA5};
      vecs[2] = '{data: 8'h00, stop_ok: 1'b1, gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_data: 8'h00};
      vecs[3] = '{data: 8'hFF, stop_ok: 1'b1, gap: 2, exp_done: 1'b1, exp_err: 1'b0, exp_data: 8'hFF};

      // Reset state
      repeat (4) @(negedge clk);
      check("rst_rx_data", 32'(rx_data), 32'(0));
      check("rst_rx_done", 32'(rx_done), 32'(0));
      check("rst_rx_busy", 32'(rx_busy), 32'(0));
      check("rst_frame_err", 32'(frame_err), 32'(0));
      check("rst_state", 32'(rx_state), 32'(IDLE));
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Directed frame table
      for (int i = 0; i < 4; i++) begin
         d0 = done_seen;
         e0 = err_seen;
         run_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].gap, -1, d_at, e_at);
         check("tbl_done", 32'(d_at), 32'(vecs[i].exp_done));
         check("tbl_err", 32'(e_at), 32'(vecs[i].exp_err));
         check("tbl_data", 32'(rx_data), 32'(vecs[i].exp_data));
         check("tbl_done_pulses", 32'(done_seen - d0), 32'(vecs[i].exp_done));
         check("tbl_err_pulses", 32'(err_seen - e0), 32'(vecs[i].exp_err));
      end

      // False start: line low for 4 ticks only
      d0 = done_seen;
      e0 = err_seen;
      busy7 = 1'b0;
      busy8 = 1'b1;
      for (int s = 0; s < 12; s++) begin
         send_slot((s < 4) ? 1'b0 : 1'b1, bp, dp, ep);
         if (s == 7) busy7 = bp;
         if (s == 8) busy8 = bp;
      end
      check("fs_busy_before_check", 32'(busy7), 32'(1));
      check("fs_busy_after_check", 32'(busy8), 32'(0));
      check("fs_no_done", 32'(done_seen - d0), 32'(0));
      check("fs_no_err", 32'(err_seen - e0), 32'(0));
      check("fs_data_kept", 32'(rx_data), 32'(8'hFF));

      // Reset during data bit 4 of 0x55
      for (int s = 0; s < 86; s++) begin
         if (s < 16) send_slot(1'b0, bp, dp, ep);
         else        send_slot(((8'h55 >> ((s-16)/16)) & 8'h01) != 0, bp, dp, ep);
      end
      d0 = done_seen;
      e0 = err_seen;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_rx_data", 32'(rx_data), 32'(0));
      check("mid_rst_rx_done", 32'(rx_done), 32'(0));
      check("mid_rst_rx_busy", 32'(rx_busy), 32'(0));
      check("mid_rst_frame_err", 32'(frame_err), 32'(0));
      check("mid_rst_state", 32'(rx_state), 32'(IDLE));
      reset_n = 1'b1;
      exp_q.delete();
      model_data = 8'h00;
      for (int s = 0; s < 20; s++) send_slot(1'b1, bp, dp, ep);
      check("mid_rst_no_strobe", 32'((done_seen - d0) + (err_seen - e0)), 32'(0));
      run_frame(8'h81, 1'b1, 2, -1, d_at, e_at);
      check("post_rst_0x81", 32'(rx_data), 32'(8'h81));

      // One-tick high glitch at the centre of bit 1 of 0xF0
`ifdef UART_RX_MAJORITY_EN
      g_exp = 8'hF0;
`else
      g_exp = 8'hF2;
`endif
      run_frame(8'hF0, 1'b1, 4, 16*2 + 7, d_at, e_at);
      check("glitch_bit1", 32'(rx_data), 32'(g_exp));

      // Random frames against the line-sampling model
      for (int i = 0; i < 20; i++) begin
         run_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                   $urandom_range(0, 5), -1, d_at, e_at);
      end

      check("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
